spi_tx_shifter: RTL and testbench
=================================

// Module: spi_tx_shifter
// PURPOSE
//   SPI responder transmit path: accepts a parallel word via valid/ready, shifts it out MSB-first on miso
//   during a chip-select frame (SPI mode 0: CPOL=0, CPHA=0). Sits beside the enabled-register storage
//   and drives the data back toward the SPI initiator. sclk and cs_n are oversampled in the clk domain.
// PARAMETERS
//   WIDTH     8   bits per frame (2..32)
// PORTS
//   clk          in   1      system clock; >= 8x sclk frequency
//   reset        in   1      asynchronous, active-high reset
//   tx_data      in   WIDTH  word to transmit
//   tx_valid     in   1      tx_data valid
//   tx_ready     out  1      block can accept a word
//   sclk         in   1      SPI serial clock from initiator (async to clk)
//   cs_n         in   1      SPI chip select, active-low (async to clk)
//   miso         out  1      serial data out
//   miso_oe      out  1      output enable for miso pad (1 while cs_n asserted)
//   tx_done      out  1      1-cycle pulse: full WIDTH-bit frame sent
//   tx_underrun  out  1      1-cycle pulse: frame started with no word loaded
//   tx_abort     out  1      1-cycle pulse: cs_n deasserted before WIDTH bits sent
// BEHAVIOUR
//   - Reset (async, active-high): state=IDLE, tx_ready=1, miso=0, miso_oe=0, all pulses 0, regs cleared.
//   - Inputs sclk/cs_n pass sync stage then edge detect; events (sclk_rise, sclk_fall, cs_fall, cs_rise)
//     are 1-clk pulses seen 3 clk after pin change (2 with SPI_TX_SYNC_EN undefined). All below is clk-domain.
//   - States: IDLE -> ARMED -> SHIFT -> IDLE.
//   - IDLE: tx_ready=1. tx_valid&tx_ready: hold_reg<=tx_data, -> ARMED next cycle (tx_ready=0).
//     cs_fall in IDLE: shift_reg<=0, tx_underrun pulse, -> SHIFT (all-zero frame).
//     tx_valid and cs_fall same cycle: word accepted and used for this frame; no underrun.
//   - ARMED: tx_ready=0; on cs_fall: shift_reg<=hold_reg, bit_cnt<=0, -> SHIFT.
//   - SHIFT: miso=shift_reg[WIDTH-1] (first bit valid before first sclk rise).
//     sclk_rise: bit_cnt++. If bit_cnt becomes WIDTH: tx_done pulse same cycle, -> IDLE.
//     sclk_fall with bit_cnt<WIDTH: shift_reg<<=1 (LSB fill 0). sclk_fall before any rise is ignored.
//     cs_rise before WIDTH rises: tx_abort pulse, -> IDLE, word discarded (not retransmitted).
//   - miso_oe = synchronized cs asserted; miso forced 0 whenever miso_oe=0.
//   - tx_ready never asserted in ARMED/SHIFT; word for next frame is loaded after tx_done.
//   - Extra sclk edges after WIDTH bits in same frame: ignored, miso=0. cs_rise after tx_done: no pulse.
//   - bit_cnt width $clog2(WIDTH+1); no wrap: saturates at WIDTH.
//   - reset mid-frame: immediate return to IDLE state values; no pulses emitted.
// CONFIGURATION
//   SPI_TX_SYNC_EN defined: 2-flop synchronizers on sclk and cs_n ahead of edge detect (3-clk latency).
//   Undefined: single capture flop only (2-clk latency); legal only when sclk/cs_n are clk-synchronous.
// STRUCTURE
//   Shared package spi_pkg (header spi_pkg.vh): state encodings SPI_IDLE/SPI_ARMED/SPI_SHIFT,
//   SPI_DEFAULT_WIDTH=8, SPI_SYNC_STAGES; reused by the matching receive shifter.
//   One sub-module: spi_edge_detect (sync + rise/fall pulse for one input), instanced for sclk and cs_n.
// TESTING
//   1 Load 8'hA5, cs_n fall, 8 mode-0 sclk cycles -> miso 1,0,1,0,0,1,0,1 at rises; tx_done once; tx_ready=1.
//   2 cs_n fall with no word loaded -> tx_underrun pulse, miso=0 for 8 bits, tx_done at end.
//   3 Load 8'hFF, cs_n rises after 3 sclk -> tx_abort pulse, tx_done never, IDLE, tx_ready=1.
//   4 tx_valid held during SHIFT -> tx_ready=0, word not captured until after tx_done; next frame sends it.
//   5 Assert reset during bit 4 of 8'h3C -> miso=0, miso_oe=0, tx_ready=1 asynchronously, no pulses.
//   6 Both macro settings: measure cs_n fall to miso_oe rise = 3 clk (defined) / 2 clk (undefined).

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared definitions for the SPI responder shift paths (transmit
//            and the matching receive shifter).
// Contents : SPI_STATE_W / SPI_IDLE / SPI_ARMED / SPI_SHIFT state encodings,
//            SPI_DEFAULT_WIDTH, SPI_SYNC_STAGES.
// Config   : SPI_TX_SYNC_EN defined   -> 2 synchronizer flops per SPI input
//            SPI_TX_SYNC_EN undefined -> single capture flop (inputs must be
//                                        clk-synchronous)
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_STATE_W = 2;

    localparam logic [SPI_STATE_W-1:0] SPI_IDLE  = 2'd0;
    localparam logic [SPI_STATE_W-1:0] SPI_ARMED = 2'd1;
    localparam logic [SPI_STATE_W-1:0] SPI_SHIFT = 2'd2;

    localparam int SPI_DEFAULT_WIDTH = 8;

`ifdef SPI_TX_SYNC_EN
    localparam int SPI_SYNC_STAGES = 2;
`else
    localparam int SPI_SYNC_STAGES = 1;
`endif

endpackage
`default_nettype wire

// File: rtl/spi_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : spi_edge_detect
// Purpose  : Brings one SPI pin into the clk domain and produces 1-clk rise
//            and fall pulses plus the synchronized level aligned with them.
//            Pulses appear SYNC_STAGES+1 clk edges after the pin changes.
// Ports    : clk    in  system clock
//            reset  in  asynchronous active-high reset
//            din    in  pin to observe (may be asynchronous to clk)
//            level  out synchronized level (same timing as the pulses)
//            rise   out 1-clk pulse on a 0->1 transition
//            fall   out 1-clk pulse on a 1->0 transition
// Revision : 1.0 - initial release
// ============================================================================
module spi_edge_detect #(
    parameter int   SYNC_STAGES = 1,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    // Warm-up shift register: pulses stay suppressed until both the last
    // sync stage and r_prev hold genuine pin samples, so leaving reset with
    // the pin already away from RESET_VAL does not fake an edge.
    logic [SYNC_STAGES:0]   r_warm;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_warm <= '0;
            r_prev <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_warm[0] <= 1'b1;
            for (int i = 1; i <= SYNC_STAGES; i++) begin
                r_warm[i] <= r_warm[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_warm[SYNC_STAGES] &  r_sync[SYNC_STAGES-1] & ~r_prev;
            r_fall <= r_warm[SYNC_STAGES] & ~r_sync[SYNC_STAGES-1] &  r_prev;
        end
    end

    assign level = r_prev;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/spi_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_tx_shifter
// Purpose  : SPI responder transmit path (mode 0). Accepts a word through
//            valid/ready and shifts it out MSB-first on miso during a
//            chip-select frame. sclk/cs_n are oversampled in the clk domain.
// Ports    : clk, reset (async, active-high)
//            tx_data/tx_valid/tx_ready  parallel word handshake
//            sclk, cs_n                 SPI pins from the initiator
//            miso, miso_oe              serial data and pad enable
//            tx_done     1-clk pulse, full frame sent
//            tx_underrun 1-clk pulse, frame started with no word loaded
//            tx_abort    1-clk pulse, cs_n released before WIDTH bits
// Config   : SPI_TX_SYNC_EN selects 2-flop synchronizers (3 clk event
//            latency) instead of a single capture flop (2 clk latency).
// Revision : 1.0 - initial release
// ============================================================================
module spi_tx_shifter
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             sclk,
    input  logic             cs_n,
    output logic             miso,
    output logic             miso_oe,
    output logic             tx_done,
    output logic             tx_underrun,
    output logic             tx_abort
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_unused_sclk_level;
    logic                   w_cs_rise;
    logic                   w_cs_fall;
    logic                   w_cs_level;
    logic [c_cnt_w-1:0]     w_cnt_inc;

    logic [SPI_STATE_W-1:0] r_state;
    logic [WIDTH-1:0]       r_hold;
    logic [WIDTH-1:0]       r_shift;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_ready;
    logic                   r_done;
    logic                   r_underrun;
    logic                   r_abort;

    spi_edge_detect #(
        .SYNC_STAGES (SPI_SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sclk_edge (
        .clk   (clk),
        .reset (reset),
        .din   (sclk),
        .level (w_unused_sclk_level),
        .rise  (w_sclk_rise),
        .fall  (w_sclk_fall)
    );

    // cs_n idles high, so its synchronizer resets to 1 (pad disabled).
    spi_edge_detect #(
        .SYNC_STAGES (SPI_SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_edge (
        .clk   (clk),
        .reset (reset),
        .din   (cs_n),
        .level (w_cs_level),
        .rise  (w_cs_rise),
        .fall  (w_cs_fall)
    );

    assign w_cnt_inc = r_cnt + c_cnt_one;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= SPI_IDLE;
            r_hold     <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_abort    <= 1'b0;
            case (r_state)
                SPI_IDLE: begin
                    if (w_cs_fall) begin
                        // A word offered in the same cycle as the frame start
                        // goes straight into the shifter.
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= SPI_SHIFT;
                        if (tx_valid) begin
                            r_shift <= tx_data;
                        end else begin
                            r_shift    <= '0;
                            r_underrun <= 1'b1;
                        end
                    end else if (tx_valid) begin
                        r_hold  <= tx_data;
                        r_ready <= 1'b0;
                        r_state <= SPI_ARMED;
                    end
                end
                SPI_ARMED: begin
                    if (w_cs_fall) begin
                        r_shift <= r_hold;
                        r_cnt   <= '0;
                        r_state <= SPI_SHIFT;
                    end
                end
                SPI_SHIFT: begin
                    if (w_sclk_rise && (w_cnt_inc == c_cnt_full)) begin
                        r_cnt   <= c_cnt_full;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= SPI_IDLE;
                    end else if (w_cs_rise) begin
                        r_abort <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= SPI_IDLE;
                    end else if (w_sclk_rise && (r_cnt != c_cnt_full)) begin
                        r_cnt <= w_cnt_inc;
                    end else if (w_sclk_fall && (r_cnt != '0) && (r_cnt != c_cnt_full)) begin
                        // The initiator has sampled the current bit; present the next.
                        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    end
                end
                default: begin
                    r_state <= SPI_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign miso_oe     = ~w_cs_level;
    assign miso        = miso_oe & (r_state == SPI_SHIFT) & r_shift[WIDTH-1];
    assign tx_ready    = r_ready;
    assign tx_done     = r_done;
    assign tx_underrun = r_underrun;
    assign tx_abort    = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_tx_shifter
// Purpose  : Scoreboard bench for spi_tx_shifter. Stimulus pushes expected
//            miso bits and status pulses into queues; independent monitors
//            pop and compare when the DUT presents them.
// Config   : SPI_TX_SYNC_EN selects the expected cs_n -> miso_oe latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_tx_shifter;

    localparam int W = 8;
`ifdef SPI_TX_SYNC_EN
    localparam int EXP_LAT = 3;
`else
    localparam int EXP_LAT = 2;
`endif
    localparam int EV_UNDERRUN = 1;
    localparam int EV_DONE     = 2;
    localparam int EV_ABORT    = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         sclk;
    logic         cs_n;
    logic         miso;
    logic         miso_oe;
    logic         tx_done;
    logic         tx_underrun;
    logic         tx_abort;

    int n_checks = 0;
    int n_errors = 0;

    bit           bit_q[$];
    int           ev_q[$];
    bit           model_loaded = 1'b0;
    logic [W-1:0] model_word   = '0;

    always #5 clk = ~clk;

    spi_tx_shifter #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_done     (tx_done),
        .tx_underrun (tx_underrun),
        .tx_abort    (tx_abort)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_bit(input logic [W-1:0] w, input int i);
        return (i < W) ? w[W-1-i] : 1'b0;
    endfunction

    // Frame of n sclk cycles: bits observed at each rise, then status pulses.
    task automatic model_frame(input int n);
        logic [W-1:0] w;
        if (!model_loaded) ev_q.push_back(EV_UNDERRUN);
        w = model_loaded ? model_word : '0;
        for (int i = 0; i < n; i++) bit_q.push_back(model_bit(w, i));
        ev_q.push_back((n >= W) ? EV_DONE : EV_ABORT);
        model_loaded = 1'b0;
    endtask

    // ---------------- monitors ----------------
    initial begin
        bit exp_b;
        forever begin
            @(posedge sclk);
            if (!cs_n && !reset) begin
                if (bit_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL miso_bit: unexpected sclk rise, miso=%0b at %0t", miso, $time);
                end else begin
                    exp_b = bit_q.pop_front();
                    check("miso_bit", miso, exp_b);
                end
            end
        end
    end

    task automatic pulse_seen(input int ev);
        if (ev_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pulse_kind: got event %0d expected none at %0t", ev, $time);
        end else begin
            check("pulse_kind", ev, ev_q.pop_front());
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (tx_underrun) pulse_seen(EV_UNDERRUN);
                if (tx_done)     pulse_seen(EV_DONE);
                if (tx_abort)    pulse_seen(EV_ABORT);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- drivers ----------------
    task automatic load_word(input logic [W-1:0] w);
        int guard = 0;
        @(negedge clk);
        while (!tx_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!tx_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL load_timeout: tx_ready=%0b required 1", tx_ready);
        end else begin
            tx_data  = w;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid     = 1'b0;
            model_loaded = 1'b1;
            model_word   = w;
        end
    endtask

    task automatic cs_start();
        int lat = 0;
        @(negedge clk);
        cs_n = 1'b0;
        while (!miso_oe && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("cs_to_oe_latency", lat, EXP_LAT);
        repeat (8) @(negedge clk);
    endtask

    task automatic sclk_cycles(input int n);
        repeat (n) begin
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic cs_end();
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check("tx_ready_after_frame", tx_ready, 1);
        check("miso_oe_after_frame", miso_oe, 0);
    endtask

    task automatic frame(input int n);
        model_frame(n);
        cs_start();
        sclk_cycles(n);
        cs_end();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] w;
        int           n;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        sclk     = 1'b0;
        cs_n     = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_miso", miso, 0);
        check("reset_miso_oe", miso_oe, 0);
        check("reset_pulses", {tx_done, tx_underrun, tx_abort}, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Plain frame of 8'hA5
        load_word(8'hA5);
        check("tx_ready_armed", tx_ready, 0);
        frame(W);

        // No word loaded: underrun, zeros, done
        frame(W);

        // Early chip-select release: abort
        load_word(8'hFF);
        frame(3);

        // Word offered during a frame is only taken after tx_done
        load_word(8'h5A);
        model_frame(W);
        fork
            begin
                cs_start();
                sclk_cycles(W);
            end
            begin
                repeat (40) @(negedge clk);
                tx_data  = 8'hC3;
                tx_valid = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    repeat (10) @(negedge clk);
                    check("tx_ready_busy", tx_ready, 0);
                end
            end
        join
        tx_valid     = 1'b0;
        model_loaded = 1'b1;
        model_word   = 8'hC3;
        check("tx_ready_after_capture", tx_ready, 0);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        frame(W);

        // Reset in the middle of 8'h3C (during bit 4)
        load_word(8'h3C);
        for (int i = 0; i < 5; i++) bit_q.push_back(model_bit(8'h3C, i));
        model_loaded = 1'b0;
        cs_start();
        sclk_cycles(4);
        sclk = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset_miso", miso, 0);
        check("mid_reset_miso_oe", miso_oe, 0);
        check("mid_reset_tx_ready", tx_ready, 1);
        check("mid_reset_pulses", {tx_done, tx_underrun, tx_abort}, 0);
        @(negedge clk);
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("post_reset_miso_oe", miso_oe, 1);
        check("post_reset_miso", miso, 0);
        check("post_reset_tx_ready", tx_ready, 1);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_oe_off", miso_oe, 0);

        // Randomized frames: optional word, 0..W+2 sclk cycles
        for (int f = 0; f < 12; f++) begin
            w = W'($urandom);
            if ($urandom_range(0, 3) != 0) load_word(w);
            n = $urandom_range(0, W + 2);
            frame(n);
        end

        repeat (20) @(negedge clk);
        check("bit_queue_empty", bit_q.size(), 0);
        check("event_queue_empty", ev_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
